cache_assoc_wb: RTL
===================

Name: cache_assoc_wb

Overview:
- Parametrised set-associative, write-back successor to the direct-mapped 32x64 cache memory.
- Provides:
  - multi-port combinational tag-match reads;
  - allocate-on-write with LRU replacement and per-line dirty bits;
  - a registered eviction channel with valid/ready handshake;
  - a sequential flush engine that writes back dirty lines and invalidates the whole array.
- Sits between the LSQ/fetch read ports and the memory-side writeback path.

Parameters:
- NUM_SETS, 32, number of sets (power of 2); IDX = $clog2(NUM_SETS).
- ASSOC, 2, ways per set (power of 2, >=2); WB = $clog2(ASSOC).
- TAG_BITS, 8, tag width.
- DATA_BITS, 64, line width.
- RD_PORTS, 2, independent read ports.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- rd_en  in  RD_PORTS  per-port read enable.
- rd_idx  in  RD_PORTS x IDX  read set index.
- rd_tag  in  RD_PORTS x TAG_BITS  read tag.
- rd_data  out  RD_PORTS x DATA_BITS  hit line data; 0 on miss.
- rd_valid  out  RD_PORTS  hit.
- wr_en  in  1  write/allocate request.
- wr_ready  out  1  write accepted this cycle.
- wr_idx  in  IDX  write set.
- wr_tag  in  TAG_BITS  write tag.
- wr_data  in  DATA_BITS  write data.
- wr_dirty  in  1  mark line dirty (store) vs clean (refill).
- evict_valid  out  1  dirty victim presented.
- evict_ready  in  1  downstream accepts victim.
- evict_idx  out  IDX  victim set.
- evict_tag  out  TAG_BITS  victim tag.
- evict_data  out  DATA_BITS  victim data.
- flush_req  in  1  start flush (sampled when idle).
- busy  out  1  flush in progress.
- flush_done  out  1  one-cycle pulse when flush completes.

Behaviour:
- Reset (reset_n low, asynchronous):
  - valid, dirty and age state cleared; FSM to IDLE.
  - evict_valid=0, busy=0, flush_done=0.
  - Data/tag arrays not reset.
  - All outputs are defined while reset is held.
- Reads:
  - Combinational, same cycle.
  - rd_valid[p] = rd_en[p] & !busy & (exactly one way in set rd_idx[p] valid with tag==rd_tag[p]).
  - No write-to-read forwarding: a read in the same cycle as a write to the same set sees pre-write contents.
- Age (LRU):
  - Per-line WB-bit age; 0 = MRU.
  - A touch of way w sets age[w]=0 and increments every valid way whose age < old age[w].
  - Touch sources: an accepted write, and a hit on port 0 only.
  - If both target the same set in one cycle, the write touch wins and the port-0 touch is dropped.
- Writes:
  - wr_ready = !busy & !(evict_valid & !evict_ready).
  - Accepted on wr_en & wr_ready at the clock edge.
  - Hit (tag match, valid): data overwritten in place; dirty |= wr_dirty.
  - Miss, victim selection: lowest-index invalid way; else the way with age ASSOC-1.
  - If the victim is valid & dirty, its idx/tag/data are registered into evict_* and evict_valid=1 the next cycle.
  - The new line is then installed with valid=1 and dirty=wr_dirty.
  - A clean victim is dropped silently.
- Eviction handshake:
  - Payload holds stable while evict_valid & !evict_ready.
  - evict_valid clears on the cycle after evict_valid & evict_ready.
  - A write accepted in the same cycle as a handshake may load a new victim; that is back-to-back and legal.
- Flush FSM, states IDLE, SWEEP, DONE:
  - IDLE->SWEEP when flush_req & !evict_valid. Cursor (set,way) starts at (0,0); busy=1.
  - SWEEP visits one (set,way) per cycle, stalling while evict_valid & !evict_ready.
    - Valid & dirty lines are loaded to evict_*.
    - Every visited line is cleared: valid=0, dirty=0, age=0.
  - After (NUM_SETS-1, ASSOC-1) the FSM goes to DONE and waits for the evict channel to drain.
  - DONE->IDLE emits flush_done=1 for one cycle; busy falls the same cycle.
  - flush_req while busy is ignored. wr_en while busy is not accepted (wr_ready=0).
- Reset mid-flush: aborts immediately to IDLE; all lines invalid; no flush_done.
- Multiple valid ways matching one tag is illegal by construction. Assertion: at most one match per lookup.

Test Plan:
- Reset, then read idx 5 tag 0x12 on both ports -> rd_valid=00, rd_data=0.
- Write idx 3 tag 0xA1 data 0x1111 clean; next cycle read port0 idx3 tag 0xA1 -> rd_valid[0]=1, rd_data[0]=0x1111. Same-cycle read during the write -> rd_valid=0.
- ASSOC=2, set 7:
  - write tag 0x01 dirty, then tag 0x02 clean;
  - port-0 hit tag 0x01;
  - write tag 0x03 -> way holding 0x02 replaced, evict_valid stays 0.
  - Repeat without the hit -> evict_valid=1, evict_tag=0x01, evict_idx=7.
- Eviction backpressure: hold evict_ready=0 -> evict payload stable, wr_ready=0. Raise evict_ready -> evict_valid drops next cycle, wr_ready=1.
- Flush with 3 dirty lines and evict_ready toggling 1/0:
  - exactly 3 evict handshakes with correct tags;
  - busy high throughout;
  - flush_done one pulse;
  - all subsequent reads miss;
  - default parameters take >= 64 cycles.
- Assert reset_n low for 1 cycle mid-flush -> busy=0 and evict_valid=0 immediately, no flush_done, all reads miss.

Source files
------------

// File: rtl/cache_assoc_wb.sv
// Set-associative write-back line cache: combinational multi-port lookup,
// LRU allocate-on-write, registered dirty-victim channel and a flush sweeper.
module cache_assoc_wb #(
  parameter int NUM_SETS  = 32,
  parameter int ASSOC     = 2,
  parameter int TAG_BITS  = 8,
  parameter int DATA_BITS = 64,
  parameter int RD_PORTS  = 2,
  localparam int IDX = $clog2(NUM_SETS),
  localparam int WB  = $clog2(ASSOC)
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [RD_PORTS-1:0]                  rd_en,
  input  logic [RD_PORTS-1:0][IDX-1:0]         rd_idx,
  input  logic [RD_PORTS-1:0][TAG_BITS-1:0]    rd_tag,
  output logic [RD_PORTS-1:0][DATA_BITS-1:0]   rd_data,
  output logic [RD_PORTS-1:0]                  rd_valid,
  input  logic                                 wr_en,
  output logic                                 wr_ready,
  input  logic [IDX-1:0]                       wr_idx,
  input  logic [TAG_BITS-1:0]                  wr_tag,
  input  logic [DATA_BITS-1:0]                 wr_data,
  input  logic                                 wr_dirty,
  output logic                                 evict_valid,
  input  logic                                 evict_ready,
  output logic [IDX-1:0]                       evict_idx,
  output logic [TAG_BITS-1:0]                  evict_tag,
  output logic [DATA_BITS-1:0]                 evict_data,
  input  logic                                 flush_req,
  output logic                                 busy,
  output logic                                 flush_done
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  localparam logic [WB-1:0] AGE_MAX = WB'(ASSOC - 1);

  logic [TAG_BITS-1:0]  tag_mem  [NUM_SETS][ASSOC];
  logic [DATA_BITS-1:0] data_mem [NUM_SETS][ASSOC];
  logic [ASSOC-1:0]     valid_q  [NUM_SETS];
  logic [ASSOC-1:0]     dirty_q  [NUM_SETS];
  logic [WB-1:0]        age_q    [NUM_SETS][ASSOC];

  state_t            state_q, state_n;
  logic [IDX+WB-1:0] cur_q, cur_n;
  logic              done_q, done_n;
  logic [IDX-1:0]    sw_set;
  logic [WB-1:0]     sw_way;
  logic              sweep_go, wr_fire, rd_touch, ev_load_wr, ev_load_sw;

  logic [ASSOC-1:0]  rd_match [RD_PORTS];
  logic [WB-1:0]     rd_way0;
  logic [ASSOC-1:0]  wr_match;
  logic              wr_hit, vic_found;
  logic [WB-1:0]     wr_way, victim, old_wr, old_rd;
  logic [WB-1:0]     age_wr [ASSOC];
  logic [WB-1:0]     age_rd [ASSOC];

  assign busy       = (state_q != IDLE);
  assign flush_done = done_q;
  assign wr_ready   = !busy && !(evict_valid && !evict_ready);
  assign wr_fire    = wr_en && wr_ready;
  assign sw_set     = cur_q[IDX+WB-1:WB];
  assign sw_way     = cur_q[WB-1:0];
  assign sweep_go   = (state_q == SWEEP) && !(evict_valid && !evict_ready);

  always_comb begin
    rd_way0 = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_data[p] = '0;
      for (int w = 0; w < ASSOC; w++)
        rd_match[p][w] = valid_q[rd_idx[p]][w] && (tag_mem[rd_idx[p]][w] == rd_tag[p]);
      rd_valid[p] = rd_en[p] && !busy && (rd_match[p] != '0) &&
                    ((rd_match[p] & (rd_match[p] - ASSOC'(1))) == '0);
      for (int w = 0; w < ASSOC; w++)
        if (rd_valid[p] && rd_match[p][w]) begin
          rd_data[p] = data_mem[rd_idx[p]][w];
          if (p == 0) rd_way0 = WB'(w);
        end
    end
  end

  always_comb begin
    victim    = '0;
    vic_found = 1'b0;
    for (int w = 0; w < ASSOC; w++)
      wr_match[w] = valid_q[wr_idx][w] && (tag_mem[wr_idx][w] == wr_tag);
    wr_hit = |wr_match;
    for (int w = 0; w < ASSOC; w++)
      if (!vic_found && !valid_q[wr_idx][w]) begin
        victim    = WB'(w);
        vic_found = 1'b1;
      end
    if (!vic_found)
      for (int w = 0; w < ASSOC; w++)
        if (age_q[wr_idx][w] == AGE_MAX) victim = WB'(w);
    wr_way = victim;
    for (int w = 0; w < ASSOC; w++)
      if (wr_match[w]) wr_way = WB'(w);
    // An invalid way counts as oldest, so installing into it ages every live way.
    old_wr = valid_q[wr_idx][wr_way] ? age_q[wr_idx][wr_way] : AGE_MAX;
    old_rd = age_q[rd_idx[0]][rd_way0];
    for (int w = 0; w < ASSOC; w++) begin
      age_wr[w] = age_q[wr_idx][w];
      if (WB'(w) == wr_way)
        age_wr[w] = '0;
      else if (valid_q[wr_idx][w] && (age_q[wr_idx][w] < old_wr))
        age_wr[w] = age_q[wr_idx][w] + WB'(1);
      age_rd[w] = age_q[rd_idx[0]][w];
      if (WB'(w) == rd_way0)
        age_rd[w] = '0;
      else if (valid_q[rd_idx[0]][w] && (age_q[rd_idx[0]][w] < old_rd))
        age_rd[w] = age_q[rd_idx[0]][w] + WB'(1);
    end
  end

  assign rd_touch   = rd_valid[0] && !(wr_fire && (wr_idx == rd_idx[0]));
  assign ev_load_wr = wr_fire && !wr_hit && valid_q[wr_idx][victim] && dirty_q[wr_idx][victim];
  assign ev_load_sw = sweep_go && valid_q[sw_set][sw_way] && dirty_q[sw_set][sw_way];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < ASSOC; w++) age_q[s][w] <= '0;
      end
    end else if (sweep_go) begin
      valid_q[sw_set][sw_way] <= 1'b0;
      dirty_q[sw_set][sw_way] <= 1'b0;
      age_q[sw_set][sw_way]   <= '0;
    end else begin
      if (rd_touch)
        for (int w = 0; w < ASSOC; w++) age_q[rd_idx[0]][w] <= age_rd[w];
      if (wr_fire) begin
        valid_q[wr_idx][wr_way] <= 1'b1;
        dirty_q[wr_idx][wr_way] <= (wr_hit && dirty_q[wr_idx][wr_way]) || wr_dirty;
        for (int w = 0; w < ASSOC; w++) age_q[wr_idx][w] <= age_wr[w];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_fire) begin
      tag_mem[wr_idx][wr_way]  <= wr_tag;
      data_mem[wr_idx][wr_way] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      evict_valid <= 1'b0;
      evict_idx   <= '0;
      evict_tag   <= '0;
      evict_data  <= '0;
    end else if (ev_load_wr) begin
      evict_valid <= 1'b1;
      evict_idx   <= wr_idx;
      evict_tag   <= tag_mem[wr_idx][victim];
      evict_data  <= data_mem[wr_idx][victim];
    end else if (ev_load_sw) begin
      evict_valid <= 1'b1;
      evict_idx   <= sw_set;
      evict_tag   <= tag_mem[sw_set][sw_way];
      evict_data  <= data_mem[sw_set][sw_way];
    end else if (evict_ready) begin
      evict_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cur_q   <= cur_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cur_n   = cur_q;
    done_n  = 1'b0;
    case (state_q)
      IDLE:
        if (flush_req && !evict_valid) begin
          state_n = SWEEP;
          cur_n   = '0;
        end
      SWEEP:
        if (sweep_go) begin
          cur_n = cur_q + (IDX+WB)'(1);
          if (&cur_q) state_n = DONE;
        end
      DONE:
        if (!evict_valid) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end

  always @(posedge clock) begin
    if (reset_n) begin
      for (int p = 0; p < RD_PORTS; p++)
        assert (!rd_en[p] || $countones(rd_match[p]) <= 1)
          else $error("multiple ways match on read port %0d", p);
      assert (!wr_en || $countones(wr_match) <= 1) else $error("multiple ways match on write");
    end
  end

endmodule
